// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory-bus slave.
// Imported by the slave top and its storage array.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 48;

  localparam logic [7:0] CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_e;

endpackage

// File: rtl/mem_bus_array.sv
// DEPTH x DATA_W flop storage, async clear,
// one write port, one combinational read port.
module mem_bus_array import mem_bus_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Unimplemented rows read as zero; the top masks them anyway.
  assign rok   = {1'b0, raddr} < LIM;
  assign rdata = rok ? mem[raddr] : '0;

endmodule

// File: rtl/mem_bus_slave.sv
// Single-cycle memory-bus slave: FSM, range check,
// registered read data and saturating access counters.
module mem_bus_slave import mem_bus_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic [1:0]        state,
  output logic [7:0]        wr_cnt,
  output logic [7:0]        rd_cnt
);

  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

  state_e            cur;
  state_e            nxt;
  logic              in_rng;
  logic              wr_go;
  logic              rd_go;
  logic              rd_ok;
  logic              oor;
  logic [DATA_W-1:0] mem_q;

  assign in_rng = {1'b0, addr} < LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = IDLE;
    unique case (1'b1)
      !en:      nxt = IDLE;
      en && wr: nxt = WR_BURST;
      default:  nxt = RD_BURST;
    endcase
  end

  always_comb begin
    wr_go = en & wr & in_rng;
    rd_go = en & ~wr;
    rd_ok = rd_go & in_rng;
    oor   = en & ~in_rng;
    state = cur;
  end

  mem_bus_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_go),
    .waddr (addr),
    .wdata (wdata),
    .raddr (addr),
    .rdata (mem_q)
  );

  // Out-of-range reads still complete, returning all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= rd_go;
      err    <= oor;
      if (rd_go) rdata <= in_rng ? mem_q : '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_go && wr_cnt != CNT_MAX)
        wr_cnt <= wr_cnt + 8'd1;
      if (rd_ok && rd_cnt != CNT_MAX)
        rd_cnt <= rd_cnt + 8'd1;
    end
  end

endmodule
